// File: rtl/bcd_calc_pkg.sv
// Shared constants for the keypad-driven BCD calculator front end:
// key codes, nibble width and the entry-sequencer state type.
package bcd_calc_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_EQ    = 4'd12;
    localparam logic [3:0] KEY_CLR   = 4'd13;

    typedef enum logic [1:0] {
        S_A,
        S_B,
        S_RES
    } state_t;

endpackage

// File: rtl/bcd_digit_shift.sv
// One packed-BCD operand register: clear, parallel load or shift-in of a digit.
// With OVF_EN set, a shift that would drop a nonzero leading digit is refused.
module bcd_digit_shift
    import bcd_calc_pkg::*;
#(
    parameter int W      = 8,
    parameter bit OVF_EN = 1'b0
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                load,
    input  logic [W-1:0]        load_val,
    input  logic                shift,
    input  logic [NIBBLE_W-1:0] digit,
    output logic [W-1:0]        value,
    output logic                rejected
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         msd_nz;

    assign msd_nz = |value_q[W-1 -: NIBBLE_W];

    // Clear beats load beats shift; a leading zero may always be shifted out.
    always_comb begin
        value_d  = value_q;
        rejected = 1'b0;
        if (clr) begin
            value_d = '0;
        end else if (load) begin
            value_d = load_val;
        end else if (shift) begin
            if (OVF_EN && msd_nz) begin
                rejected = 1'b1;
            end else begin
                value_d = {value_q[W-NIBBLE_W-1:0], digit};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/bcd_key_entry_seq.sv
// Keypad operand sequencer feeding a combinational 2-digit BCD add/sub unit.
// Define BCD_ENTRY_OVF_EN to reject digits that would push out a nonzero leading digit.
module bcd_key_entry_seq
    import bcd_calc_pkg::*;
#(
    parameter int DIGITS = 2
)
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         key_valid,
    output logic                         key_ready,
    input  logic [3:0]                   key_code,
    output logic [NIBBLE_W*DIGITS-1:0]   a,
    output logic [NIBBLE_W*DIGITS-1:0]   b,
    output logic                         sub,
    input  logic [NIBBLE_W*DIGITS-1:0]   result_in,
    output logic                         op_valid,
    output logic [NIBBLE_W*DIGITS-1:0]   display,
    output logic                         entry_err
);

    localparam int W = NIBBLE_W * DIGITS;
`ifdef BCD_ENTRY_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    state_t       state_q, state_d;
    logic         sub_q, sub_d;
    logic [W-1:0] res_q, res_d;
    logic         op_pend_q, op_pend_d;
    logic         err_q, err_d;

    logic         accept;
    logic         is_digit;
    logic         a_clr, a_load, a_shift, a_rej;
    logic         b_clr, b_shift, b_rej;
    logic [W-1:0] a_load_val;

    assign accept   = key_valid && !op_pend_q;
    assign is_digit = (key_code <= 4'd9);

    always_comb begin
        state_d    = state_q;
        sub_d      = sub_q;
        res_d      = res_q;
        op_pend_d  = 1'b0;
        a_clr      = 1'b0;
        a_load     = 1'b0;
        a_shift    = 1'b0;
        a_load_val = res_q;
        b_clr      = 1'b0;
        b_shift    = 1'b0;

        // The unit has had the whole '=' cycle to settle, so sample it now.
        if (op_pend_q) begin
            res_d = result_in;
        end

        if (accept) begin
            if (key_code == KEY_CLR) begin
                a_clr   = 1'b1;
                b_clr   = 1'b1;
                res_d   = '0;
                sub_d   = 1'b0;
                state_d = S_A;
            end else begin
                case (state_q)
                    S_A: begin
                        if (is_digit) begin
                            a_shift = 1'b1;
                        end else if (key_code == KEY_PLUS || key_code == KEY_MINUS) begin
                            sub_d   = (key_code == KEY_MINUS);
                            b_clr   = 1'b1;
                            state_d = S_B;
                        end
                    end
                    S_B: begin
                        if (is_digit) begin
                            b_shift = 1'b1;
                        end else if (key_code == KEY_PLUS || key_code == KEY_MINUS) begin
                            sub_d = (key_code == KEY_MINUS);
                        end else if (key_code == KEY_EQ) begin
                            op_pend_d = 1'b1;
                            state_d   = S_RES;
                        end
                    end
                    S_RES: begin
                        // A digit starts a fresh calculation; an operator chains on the result.
                        if (is_digit) begin
                            a_load     = 1'b1;
                            a_load_val = {{(W-NIBBLE_W){1'b0}}, key_code};
                            b_clr      = 1'b1;
                            sub_d      = 1'b0;
                            state_d    = S_A;
                        end else if (key_code == KEY_PLUS || key_code == KEY_MINUS) begin
                            a_load  = 1'b1;
                            b_clr   = 1'b1;
                            sub_d   = (key_code == KEY_MINUS);
                            state_d = S_B;
                        end else if (key_code == KEY_EQ) begin
                            op_pend_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_A;
                    end
                endcase
            end
        end

        err_d = a_rej | b_rej;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_A;
            sub_q     <= 1'b0;
            res_q     <= '0;
            op_pend_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sub_q     <= sub_d;
            res_q     <= res_d;
            op_pend_q <= op_pend_d;
            err_q     <= err_d;
        end
    end

    bcd_digit_shift #(.W(W), .OVF_EN(OVF_EN)) u_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (a_clr),
        .load     (a_load),
        .load_val (a_load_val),
        .shift    (a_shift),
        .digit    (key_code),
        .value    (a),
        .rejected (a_rej)
    );

    bcd_digit_shift #(.W(W), .OVF_EN(OVF_EN)) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (b_clr),
        .load     (1'b0),
        .load_val ('0),
        .shift    (b_shift),
        .digit    (key_code),
        .value    (b),
        .rejected (b_rej)
    );

    always_comb begin
        display = res_q;
        case (state_q)
            S_A:     display = a;
            S_B:     display = b;
            default: display = res_q;
        endcase
    end

    assign key_ready = !op_pend_q;
    assign op_valid  = op_pend_q;
    assign sub       = sub_q;
    assign entry_err = err_q;

endmodule
